// File: rtl/mag_sq_accumulator.sv
// rtl/mag_sq_accumulator.sv - per-sample |z|^2 pipeline with framed accumulation
module mag_sq_accumulator #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_imag,
  input  logic                in_last,
  output logic [2*DATA_W:0]   mag_out,
  output logic                mag_valid,
  output logic [2*DATA_W+8:0] sum_out,
  output logic                sum_valid,
  output logic                busy
);

  localparam int SQ_W  = 2 * DATA_W;
  localparam int MAG_W = 2 * DATA_W + 1;
  localparam int SUM_W = 2 * DATA_W + 9;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               s1_valid_q, s1_first_q, s1_last_q;
  logic [DATA_W-1:0]  s1_re_q, s1_im_q;
  logic               s2_valid_q, s2_first_q, s2_last_q;
  logic [SQ_W-1:0]    sq_re_q, sq_im_q;
  logic [MAG_W-1:0]   mag_q;
  logic               mag_valid_q;
  logic [SUM_W-1:0]   acc_q, sum_q;
  logic               sum_valid_q;

  logic               accept;
  logic               frame_end;
  logic [MAG_W-1:0]   mag_d;
  logic [SUM_W-1:0]   frame_total;

  assign accept      = in_valid & ~clear;
  assign frame_end   = (cnt_q == LAST_CNT) | in_last;
  assign mag_d       = {1'b0, sq_re_q} + {1'b0, sq_im_q};
  // The first sample of a frame seeds the total, so back-to-back frames need no idle cycle.
  assign frame_total = s2_first_q ? SUM_W'(mag_d) : acc_q + SUM_W'(mag_d);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = frame_end ? IDLE : ACCUM;
      cnt_d   = frame_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else if (clear) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      mag_valid_q <= 1'b0;
      sum_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_re_q    <= in_real;
        s1_im_q    <= in_imag;
        s1_first_q <= (cnt_q == '0);
        s1_last_q  <= frame_end;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sq_re_q    <= SQ_W'(s1_re_q) * SQ_W'(s1_re_q);
        sq_im_q    <= SQ_W'(s1_im_q) * SQ_W'(s1_im_q);
        s2_first_q <= s1_first_q;
        s2_last_q  <= s1_last_q;
      end
      mag_valid_q <= s2_valid_q;
      sum_valid_q <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        mag_q <= mag_d;
        acc_q <= frame_total;
        if (s2_last_q) sum_q <= frame_total;
      end
    end
  end

  assign mag_out   = mag_q;
  assign mag_valid = mag_valid_q;
  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: doc/mag_sq_accumulator.md
MAG_SQ_ACCUMULATOR -- requirements
Module: mag_sq_accumulator

Interface
REQ-001 Parameter: DATA_W, default 8, width of each unsigned input component.
REQ-002 Parameter: FRAME_LEN, default 256, samples per accumulation frame (range 2..256).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: clear  input  1  synchronous flush of pipeline, accumulator and frame count.
REQ-006 Port: in_valid  input  1  qualifies in_real/in_imag for one cycle.
REQ-007 Port: in_real  input  DATA_W  unsigned real component.
REQ-008 Port: in_imag  input  DATA_W  unsigned imaginary component.
REQ-009 Port: in_last  input  1  with in_valid, marks the final sample of a short frame (upstream done).
REQ-010 Port: mag_out  output  2*DATA_W+1  per-sample in_real^2 + in_imag^2.
REQ-011 Port: mag_valid  output  1  one-cycle strobe qualifying mag_out.
REQ-012 Port: sum_out  output  2*DATA_W+9  frame total, held until the next frame completes.
REQ-013 Port: sum_valid  output  1  one-cycle strobe when sum_out updates.
REQ-014 Port: busy  output  1  high while the FSM is in ACCUM.

Function
REQ-015 Sample accepted on any edge where in_valid=1 and clear=0; no backpressure; one sample per cycle sustained.
REQ-016 Pipeline: stage 1 registers inputs; stage 2 registers both squares (2*DATA_W bits each); stage 3 registers the zero-extended sum into mag_out.
REQ-017 mag_valid asserts for exactly one cycle, 3 edges after acceptance (accepted at edge E0, visible after E2), in order, no gaps.
REQ-018 All arithmetic unsigned; no truncation: max mag 130050 fits 17 bits; max frame sum 33292800 fits 25 bits.
REQ-019 FSM states IDLE and ACCUM; IDLE -> ACCUM on acceptance; ACCUM -> IDLE when a frame-ending sample is accepted with no new sample on the same edge; ACCUM -> ACCUM on frame end plus new sample.
REQ-020 Frame count increments per accepted sample; a sample ends the frame when count = FRAME_LEN-1 or in_last=1; count returns to 0 on the same edge; both conditions together end one frame only.
REQ-021 Accumulator: a frame's first sample's mag loads the accumulator (no add); later samples add; no dead cycle between back-to-back frames.
REQ-022 Frame-end mag reaching stage 3: sum_out <= accumulator + that mag on the same edge; sum_valid high for exactly that following cycle.
REQ-023 in_last on a frame's first sample yields a one-sample frame: sum_out = that mag.
REQ-024 in_valid=0 cycles insert bubbles; they neither change counts nor the accumulator.
REQ-025 clear=1: discards all in-flight samples, zeroes the frame count and accumulator, returns to IDLE, deasserts mag_valid/sum_valid the next cycle; sum_out retains its last value; clear overrides a same-edge in_valid.

Reset
REQ-026 rst_n low asynchronously forces IDLE, frame count 0, accumulator 0, pipeline registers 0, mag_out 0, mag_valid 0, sum_out 0, sum_valid 0, busy 0.
REQ-027 Reset mid-frame discards the partial frame; the first sample accepted after release starts a new frame at count 0.
REQ-028 Reset release is not synchronised internally; in_valid is low for the first edge after release.

Verification
REQ-029 Single sample (126,126), in_valid pulse -> mag_out=31752, mag_valid high exactly one cycle, 3 edges later; busy=1.
REQ-030 256 continuous samples cycling (126,127,128,129) on both components -> sum_out=8323840, one sum_valid pulse 3 edges after the 256th sample; busy=0 after.
REQ-031 256 samples of (255,255) -> sum_out=33292800; no overflow.
REQ-032 Back-to-back frames, second of 256×(0,1) -> first sum as above, second sum_out=256, no lost cycle between frames.
REQ-033 in_last on 4th sample (126..129 pattern) with in_valid gaps between samples -> sum_out=130060; next frame restarts at count 0.
REQ-034 clear asserted on 100th sample, then rst_n pulsed low mid-frame -> no sum_valid; post-clear sum_out unchanged; after reset all outputs 0; a new 256-sample frame sums correctly.
